// File: rtl/lsu_memory.sv
// lsu_memory: load/store unit owning the word-organised data array.
// Sub-word and misaligned accesses run as whole-word read-modify-write.
module lsu_memory #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEMORY_SIZE   = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [2:0]               req_ctrl,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD0  = 3'd1;
  localparam logic [2:0] S_RD1  = 3'd2;
  localparam logic [2:0] S_WR0  = 3'd3;
  localparam logic [2:0] S_WR1  = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;
  localparam int DEPTH = 1 << MEMORY_SIZE;

  logic [2:0] state;
  logic [2:0] state_nx;

  logic                   we_q;
  logic                   span_q;
  logic [1:0]             off_q;
  logic [2:0]             ctrl_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [MEMORY_SIZE-1:0] idx0_q;
  logic [MEMORY_SIZE-1:0] idx1;

  logic [31:0] buf0;
  logic [31:0] buf1;
  logic [31:0] mem [DEPTH];

  logic [2:0]  in_size;
  logic        in_illegal;
  logic        in_span;
  logic        accept;

  logic [31:0] rd_word;
  logic [31:0] nb0;
  logic [31:0] nb1;
  logic [63:0] sh;
  logic [31:0] ext;

  logic [3:0]  lane_b;
  logic [7:0]  lane_m;
  logic [63:0] bmask;
  logic [63:0] wv;
  logic [63:0] mv;

  logic unused_addr;
  assign unused_addr =
    ^req_addr[ADDRESS_WIDTH-1:MEMORY_SIZE+2];

  assign req_ready  = (state == S_IDLE) && !rst;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state == S_RESP);
  assign idx1       = idx0_q + MEMORY_SIZE'(1);

  always_comb begin
    in_size = 3'd0;
    unique case (req_ctrl[1:0])
      2'b00:   in_size = 3'd1;
      2'b01:   in_size = 3'd2;
      2'b10:   in_size = 3'd4;
      default: in_size = 3'd0;
    endcase
    in_illegal = (req_ctrl == 3'b011)
              || (req_ctrl[2] && req_ctrl[1])
              || (req_we && req_ctrl[2]);
    in_span = ({1'b0, req_addr[1:0]} + in_size) > 3'd4;
  end

  always_comb begin
    rd_word = (state == S_RD1) ? mem[idx1] : mem[idx0_q];
    nb0 = (state == S_RD0) ? rd_word : buf0;
    nb1 = (state == S_RD1) ? rd_word : buf1;
    sh  = {nb1, nb0} >> {off_q, 3'b000};
    ext = 32'd0;
    unique case (1'b1)
      ctrl_q == 3'b000: ext = {{24{sh[7]}}, sh[7:0]};
      ctrl_q == 3'b001: ext = {{16{sh[15]}}, sh[15:0]};
      ctrl_q == 3'b010: ext = sh[31:0];
      ctrl_q == 3'b100: ext = {24'd0, sh[7:0]};
      ctrl_q == 3'b101: ext = {16'd0, sh[15:0]};
      default:          ext = 32'd0;
    endcase
  end

  // store merge on the two-word view; untouched lanes keep buffered bytes
  always_comb begin
    lane_b = ctrl_q[1] ? 4'hf : (ctrl_q[0] ? 4'h3 : 4'h1);
    lane_m = {4'd0, lane_b} << off_q;
    bmask  = 64'd0;
    for (int i = 0; i < 8; i++) begin
      bmask[8*i +: 8] = {8{lane_m[i]}};
    end
    wv = {32'd0, wdata_q} << {off_q, 3'b000};
    mv = ({buf1, buf0} & ~bmask) | (wv & bmask);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          state_nx = in_illegal ? S_RESP : S_RD0;
        end
      end
      S_RD0: begin
        if (span_q)    state_nx = S_RD1;
        else if (we_q) state_nx = S_WR0;
        else           state_nx = S_RESP;
      end
      S_RD1:   state_nx = we_q ? S_WR0 : S_RESP;
      S_WR0:   state_nx = span_q ? S_WR1 : S_RESP;
      S_WR1:   state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      span_q     <= 1'b0;
      off_q      <= 2'd0;
      ctrl_q     <= 3'd0;
      wdata_q    <= '0;
      idx0_q     <= '0;
      buf0       <= 32'd0;
      buf1       <= 32'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        span_q  <= in_span;
        off_q   <= req_addr[1:0];
        ctrl_q  <= req_ctrl;
        wdata_q <= req_wdata;
        idx0_q  <= req_addr[MEMORY_SIZE+1:2];
      end
      if (state == S_RD0) buf0 <= rd_word;
      if (state == S_RD1) buf1 <= rd_word;
      if (state == S_RESP) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end else if (state_nx == S_RESP) begin
        resp_err <= (state == S_IDLE);
        if ((state == S_RD0 || state == S_RD1) && !we_q)
          resp_rdata <= ext;
        else
          resp_rdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_WR0) mem[idx0_q] <= mv[31:0];
      if (state == S_WR1) mem[idx1]   <= mv[63:32];
    end
  end

endmodule

// File: tb/tb_lsu_memory.sv
// tb_lsu_memory: random + directed checks of lsu_memory
// against a byte-addressed reference memory.
module tb_lsu_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_ctrl;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [4096];

  always #5 clk = ~clk;

  lsu_memory dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ctrl   (req_ctrl),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] c);
    return c[1] ? 4 : (c[0] ? 2 : 1);
  endfunction

  function automatic bit is_illegal(input bit we,
                                    input logic [2:0] c);
    return (c == 3) || (c == 6) || (c == 7)
        || (we && (c == 4 || c == 5));
  endfunction

  function automatic logic [31:0] ref_load(
      input logic [31:0] a, input logic [2:0] c);
    logic [31:0] v;
    int base;
    v = 32'd0;
    base = int'(a[11:0]);
    for (int i = 0; i < size_of(c); i++)
      v[8*i +: 8] = ref_mem[(base + i) % 4096];
    case (c)
      3'd0: return {{24{v[7]}}, v[7:0]};
      3'd1: return {{16{v[15]}}, v[15:0]};
      3'd4: return {24'd0, v[7:0]};
      3'd5: return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic ref_store(input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [2:0] c);
    int base;
    base = int'(a[11:0]);
    for (int i = 0; i < size_of(c); i++)
      ref_mem[(base + i) % 4096] = d[8*i +: 8];
  endtask

  task automatic do_req(input bit we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [2:0] c,
                        input string tag,
                        output logic [31:0] rd);
    bit err;
    bit span;
    int lat;
    int exp_lat;
    logic [31:0] exp_rd;
    err  = is_illegal(we, c);
    span = (int'(a[1:0]) + size_of(c)) > 4;
    exp_rd = (err || we) ? 32'd0 : ref_load(a, c);
    if (err)     exp_lat = 1;
    else if (we) exp_lat = span ? 5 : 3;
    else         exp_lat = span ? 3 : 2;
    @(negedge clk);
    for (int k = 0; k < 4 && !req_ready; k++)
      @(negedge clk);
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_ctrl  = c;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_ctrl  = 3'($urandom);
    lat = 99;
    rd  = 32'hx;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = n;
        break;
      end
    end
    check({tag, " lat"}, 32'(lat), 32'(exp_lat));
    if (lat != 99) begin
      rd = resp_rdata;
      check({tag, " err"}, 32'(resp_err), 32'(err));
      check({tag, " rdata"}, resp_rdata, exp_rd);
      check({tag, " busy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      check({tag, " one-shot"}, 32'(resp_valid), 32'd0);
      check({tag, " idle rdata"}, resp_rdata, 32'd0);
    end
    if (we && !err) ref_store(a, d, c);
  endtask

  logic [31:0] r;

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_ctrl  = 3'd0;
    repeat (3) @(negedge clk);
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst valid", 32'(resp_valid), 32'd0);
    check("rst rdata", resp_rdata, 32'd0);
    check("rst err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post rst ready", 32'(req_ready), 32'd1);

    for (int w = 0; w < 1024; w++)
      do_req(1'b1, 32'(w * 4), $urandom, 3'd2, "init", r);

    do_req(1, 32'h10, 32'h12345678, 3'd2, "sw10", r);
    do_req(0, 32'h10, 32'h0, 3'd2, "lw10", r);
    check("lw10 val", r, 32'h12345678);

    do_req(1, 32'h13, 32'h000000AB, 3'd0, "sb13", r);
    do_req(0, 32'h13, 32'h0, 3'd0, "lb13", r);
    check("lb13 val", r, 32'hFFFFFFAB);
    do_req(0, 32'h13, 32'h0, 3'd4, "lbu13", r);
    check("lbu13 val", r, 32'h000000AB);
    do_req(0, 32'h10, 32'h0, 3'd2, "lw10b", r);
    check("lw10b val", r, 32'hAB345678);

    do_req(1, 32'h20, 32'h0, 3'd2, "sw20", r);
    do_req(1, 32'h24, 32'h0, 3'd2, "sw24", r);
    do_req(1, 32'h21, 32'hDEADBEEF, 3'd2, "sw21", r);
    do_req(0, 32'h20, 32'h0, 3'd2, "lw20", r);
    check("lw20 val", r, 32'hADBEEF00);
    do_req(0, 32'h24, 32'h0, 3'd2, "lw24", r);
    check("lw24 val", r, 32'h000000DE);
    do_req(0, 32'h23, 32'h0, 3'd1, "lh23", r);
    check("lh23 val", r, 32'hFFFFDEAD);
    do_req(0, 32'h23, 32'h0, 3'd5, "lhu23", r);
    check("lhu23 val", r, 32'h0000DEAD);

    do_req(0, 32'h10, 32'h0, 3'd3, "ill ld", r);
    do_req(1, 32'h10, 32'hFFFFFFFF, 3'd4, "ill st", r);
    do_req(0, 32'h10, 32'h0, 3'd2, "lw10c", r);
    check("lw10c val", r, 32'hAB345678);

    do_req(1, 32'hFFC, 32'h44332211, 3'd2, "sw3ff", r);
    do_req(1, 32'h000, 32'h88776655, 3'd2, "sw0", r);
    do_req(0, 32'hFFD, 32'h0, 3'd2, "lw wrap", r);
    check("lw wrap val", r, 32'h55443322);

    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h21;
    req_wdata = 32'hCAFEF00D;
    req_ctrl  = 3'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid no resp", 32'(resp_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst ready", 32'(req_ready), 32'd0);
    check("mid rst valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("mid rst valid2", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid rel ready", 32'(req_ready), 32'd1);
    check("mid rel valid", 32'(resp_valid), 32'd0);
    ref_store(32'h21, 32'h00FEF00D, 3'd1);
    ref_store(32'h23, 32'h000000FE, 3'd0);
    do_req(0, 32'h20, 32'h0, 3'd2, "lw20 rst", r);
    check("lw20 rst val", r, 32'hFEF00D00);
    do_req(0, 32'h24, 32'h0, 3'd2, "lw24 rst", r);
    check("lw24 rst val", r, 32'h000000DE);

    for (int i = 0; i < 400; i++)
      do_req(1'($urandom), $urandom, $urandom,
             3'($urandom_range(0, 7)), "rand", r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_memory.md
# lsu_memory

Load/store memory unit sitting directly downstream of the data controller stage in the RISC-V datapath. It accepts one load or store request at a time, owns the word-organised data memory array, and sequences whole-word read-modify-write cycles so byte, halfword and misaligned accesses never corrupt neighbouring bytes. Accesses that cross a word boundary are split into two word accesses by an internal state machine. Results are returned on a one-cycle response strobe with RISC-V sign or zero extension applied.

## Interface
- DATA_WIDTH, 32, data path width (fixed 32; other values unsupported)
- ADDRESS_WIDTH, 32, byte address width
- MEMORY_SIZE, 10, log2 of array depth in words (default 1024 words)

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; transfer when req_valid && req_ready
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDRESS_WIDTH  byte address
- req_wdata  input  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- req_ctrl  input  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- resp_valid  output  1  one-cycle completion strobe
- resp_rdata  output  DATA_WIDTH  load result, extended; 0 for stores and errors
- resp_err  output  1  request illegal, valid with resp_valid

## Operation
- Little-endian. Word index = req_addr[MEMORY_SIZE+1:2]; higher address bits ignored. Offset = req_addr[1:0].
- Size: b = 1 byte, h/hu = 2, w = 4. Access spans when offset + size > 4; second word index = first + 1, modulo 2^MEMORY_SIZE (wraps to word 0).
- Illegal: req_ctrl in {011,110,111}, or req_we=1 with req_ctrl in {100,101}. No memory access; resp_err=1, resp_rdata=0.
- Request fields latched on accept; inputs ignored afterwards until IDLE.
- States:
  - IDLE: req_ready=1. Accept -> RESP if illegal, else RD0.
  - RD0: read first word into buf0. -> RD1 if spanning; else WR0 if store; else RESP.
  - RD1: read second word into buf1. -> WR0 if store, else RESP.
  - WR0: write buf0 with request bytes merged into lanes offset..min(3, offset+size-1). -> WR1 if spanning, else RESP.
  - WR1: write buf1 with remaining request bytes into lanes 0..(offset+size-5). -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Merge/extract on the 64-bit view {buf1, buf0} at bit offset 8*offset; only addressed bytes change, all others preserved.
- Loads: b/h sign-extend from bit 7/15; bu/hu zero-extend; w unchanged.
- No response backpressure: consumer must take resp_valid when asserted.
- Array contents not reset; uninitialised reads are X in simulation.

## Timing
- Reset: state IDLE; req_ready=0 while rst=1, 1 from first cycle after release; resp_valid=0, resp_rdata=0, resp_err=0; buf0/buf1 cleared.
- Accept at edge T. resp_valid high in cycle: aligned load T+2; spanning load T+3; aligned/byte store T+3; spanning store T+5; illegal T+1.
- req_ready=0 from cycle after accept through RESP; next accept earliest in the cycle after RESP (back-to-back aligned loads: one every 3 cycles).
- Array read synchronous: value sampled into buf at end of RD state; writes take effect at end of WR state, visible to any later request.
- resp_rdata/resp_err registered, held stable during RESP, return to 0 in IDLE.
- Reset mid-operation: state to IDLE immediately, no response issued; a spanning store reset after WR0 leaves word0 written, word1 untouched (accepted partial store).

## Test plan
- Reset, sw 0x12345678 @0x10 -> resp_valid at T+3, err 0; then lw @0x10 -> 0x12345678 at T+2.
- sb 0x000000AB @0x13, then lb @0x13 -> 0xFFFFFFAB, lbu @0x13 -> 0x000000AB, lw @0x10 -> 0xAB345678.
- Words 0x20/0x24 zeroed, sw 0xDEADBEEF @0x21 -> resp at T+5; lw @0x20 -> 0xADBEEF00, lw @0x24 -> 0x000000DE; lh @0x23 -> 0xFFFFDEAD at T+3; lhu @0x23 -> 0x0000DEAD.
- req_ctrl 011 load, and store with req_ctrl 100 -> resp_err=1, resp_rdata=0 at T+1; lw of target address shows memory unchanged.
- Wrap (MEMORY_SIZE=10): word 1023 = 0x44332211, word 0 = 0x88776655, lw @0xFFD -> 0x55443322 at T+3.
- Spanning store, assert rst during WR1 -> no resp_valid, req_ready low during reset then 1; word1 unchanged, word0 holds merged bytes.
